// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings, bit-count constants and the parity helper,
// kept in one place so the matching receiver can reuse them.
package uart_tx_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 104;
    localparam int UART_DATA_BITS            = 8;
    localparam int UART_IDX_W                = 3;
    localparam logic [UART_IDX_W-1:0] UART_LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

    localparam logic [2:0] UART_IDLE   = 3'd0;
    localparam logic [2:0] UART_START  = 3'd1;
    localparam logic [2:0] UART_DATA   = 3'd2;
    localparam logic [2:0] UART_PARITY = 3'd3;
    localparam logic [2:0] UART_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = UART_IDLE,
        ST_START  = UART_START,
        ST_DATA   = UART_DATA,
        ST_PARITY = UART_PARITY,
        ST_STOP   = UART_STOP
    } uart_state_t;

    // Odd-sense inverts the bit so data plus parity carries an odd number of ones.
    function automatic logic parityBit(input logic [UART_DATA_BITS-1:0] data, input logic oddSense);
        return (^data) ^ oddSense;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter that pulses tick for one cycle at terminal count.
// clear reloads the full period so the next bit starts with a complete CLKS_PER_BIT window.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || (r_count == '0)) begin
            r_count <= LOAD_VAL;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tick = (r_count == '0) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 by default, LSB first, registered tx line and busy flag.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD) after the data.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       transmit,
    output logic       is_transmitting,
    output logic       tx,
    output logic       tx_dropped
);

    uart_state_t                 r_state;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [UART_IDX_W-1:0]       r_bitIdx;
    logic                        r_stopCnt;
    logic                        r_tx;
    logic                        r_busy;
    logic                        r_dropped;
`ifdef UART_TX_PARITY_EN
    logic                        r_parity;
`endif

    uart_state_t                 w_nextState;
    logic [UART_DATA_BITS-1:0]   w_nextShift;
    logic [UART_IDX_W-1:0]       w_nextBitIdx;
    logic                        w_nextStopCnt;
    logic                        w_nextTx;
    logic                        w_accept;
    logic                        w_clear;
    logic                        w_tick;

    // The timer is held in reload while idle, so the start bit gets a full period.
    assign w_clear = (r_state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baudGen (
        .clk  (clk),
        .rst  (rst),
        .clear(w_clear),
        .tick (w_tick)
    );

    always_comb begin
        w_nextState   = r_state;
        w_nextShift   = r_shift;
        w_nextBitIdx  = r_bitIdx;
        w_nextStopCnt = r_stopCnt;
        w_accept      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (transmit) begin
                    w_accept      = 1'b1;
                    w_nextState   = ST_START;
                    w_nextShift   = tx_byte;
                    w_nextBitIdx  = '0;
                    w_nextStopCnt = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) w_nextState = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bitIdx == UART_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_nextState = ST_PARITY;
`else
                        w_nextState = ST_STOP;
`endif
                    end else begin
                        w_nextBitIdx = r_bitIdx + 1'b1;
                        w_nextShift  = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_nextState = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stopCnt == 1'(STOP_BITS - 1)) begin
                        w_nextState   = ST_IDLE;
                        w_nextStopCnt = 1'b0;
                    end else begin
                        w_nextStopCnt = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        // Line value is decoded from the upcoming state so tx can be registered.
        case (w_nextState)
            ST_START: w_nextTx = 1'b0;
            ST_DATA:  w_nextTx = w_nextShift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_nextTx = r_parity;
`endif
            default:  w_nextTx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bitIdx  <= '0;
            r_stopCnt <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_shift   <= w_nextShift;
            r_bitIdx  <= w_nextBitIdx;
            r_stopCnt <= w_nextStopCnt;
            r_tx      <= w_nextTx;
            r_busy    <= (w_nextState != ST_IDLE);
            r_dropped <= transmit && r_busy;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is computed from the byte as accepted, before any shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= parityBit(tx_byte, 1'(PARITY_ODD));
        end
    end
`endif

    assign tx              = r_tx;
    assign is_transmitting = r_busy;
    assign tx_dropped      = r_dropped;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (4 clk/bit 1 stop even, 3 clk/bit 2 stop odd)
// compared every cycle against a per-cycle line model built from the frame format.
module tb_uart_tx;

    localparam int NA = 4;
    localparam int SA = 1;
    localparam int OA = 0;
    localparam int NB = 3;
    localparam int SB = 2;
    localparam int OB = 1;

    logic       clk;
    logic       rstA, rstB;
    logic       transmitA, transmitB;
    logic [7:0] byteA, byteB;
    logic       busyA, busyB;
    logic       txA, txB;
    logic       dropA, dropB;

    bit qA[$];
    bit qB[$];
    bit expDropA, expDropB;
    bit truncA, truncB;
    int expLenA, expLenB;
    int runA, runB;
    int assertions;
    int failures;

    uart_tx #(.CLKS_PER_BIT(NA), .STOP_BITS(SA), .PARITY_ODD(OA)) dutA (
        .clk            (clk),
        .rst            (rstA),
        .tx_byte        (byteA),
        .transmit       (transmitA),
        .is_transmitting(busyA),
        .tx             (txA),
        .tx_dropped     (dropA)
    );

    uart_tx #(.CLKS_PER_BIT(NB), .STOP_BITS(SB), .PARITY_ODD(OB)) dutB (
        .clk            (clk),
        .rst            (rstB),
        .tx_byte        (byteB),
        .transmit       (transmitB),
        .is_transmitting(busyB),
        .tx             (txB),
        .tx_dropped     (dropB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame length in bits: start + 8 data + optional parity + stop bits.
    function automatic int frameLen(input int stops);
`ifdef UART_TX_PARITY_EN
        return 10 + stops;
`else
        return 9 + stops;
`endif
    endfunction

    function automatic bit frameBit(input logic [7:0] b, input int odd, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return (($countones(b) % 2) == 1) ^ (odd != 0);
`endif
        return 1'b1;
    endfunction

    // Line model: each queue holds the expected tx value for every remaining busy cycle.
    always @(posedge clk) begin
        if (rstA) begin
            qA.delete();
            expDropA <= 1'b0;
            truncA   <= 1'b1;
        end else begin
            expDropA <= transmitA && (qA.size() != 0);
            if (qA.size() != 0) begin
                void'(qA.pop_front());
            end else if (transmitA) begin
                for (int i = 0; i < frameLen(SA); i++)
                    for (int c = 0; c < NA; c++) qA.push_back(frameBit(byteA, OA, i));
                expLenA <= NA * frameLen(SA);
                truncA  <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rstB) begin
            qB.delete();
            expDropB <= 1'b0;
            truncB   <= 1'b1;
        end else begin
            expDropB <= transmitB && (qB.size() != 0);
            if (qB.size() != 0) begin
                void'(qB.pop_front());
            end else if (transmitB) begin
                for (int i = 0; i < frameLen(SB); i++)
                    for (int c = 0; c < NB; c++) qB.push_back(frameBit(byteB, OB, i));
                expLenB <= NB * frameLen(SB);
                truncB  <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("txA", txA, (qA.size() != 0) ? qA[0] : 1'b1);
        checkOutput("busyA", busyA, qA.size() != 0);
        checkOutput("dropA", dropA, expDropA);
        checkOutput("txB", txB, (qB.size() != 0) ? qB[0] : 1'b1);
        checkOutput("busyB", busyB, qB.size() != 0);
        checkOutput("dropB", dropB, expDropB);
        if (busyA === 1'b1) runA++;
        else begin
            if (runA > 0 && !truncA) checkOutput("busyLenA", runA, expLenA);
            runA = 0;
        end
        if (busyB === 1'b1) runB++;
        else begin
            if (runB > 0 && !truncB) checkOutput("busyLenB", runB, expLenB);
            runB = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareAll();
    endtask

    // Called just after a falling edge: one-cycle transmit strobe, then scramble the byte.
    task automatic applyStimulus(input int dut, input logic [7:0] b);
        if (dut == 0) begin transmitA = 1'b1; byteA = b; end
        else          begin transmitB = 1'b1; byteB = b; end
        tick();
        transmitA = 1'b0;
        transmitB = 1'b0;
        byteA = 8'($urandom);
        byteB = 8'($urandom);
    endtask

    task automatic waitIdle(input int dut, input int budget);
        int n = 0;
        while ((((dut == 0) ? qA.size() : qB.size()) != 0) && (n < budget)) begin
            tick();
            n++;
        end
        checkOutput("idleWithinBudget", n < budget, 1'b1);
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        runA = 0;
        runB = 0;
        rstA = 1'b1; rstB = 1'b1;
        transmitA = 1'b1; transmitB = 1'b1;
        byteA = 8'hA5; byteB = 8'h5A;
        tick();
        tick();
        checkOutput("rstTxA", txA, 1'b1);
        checkOutput("rstBusyA", busyA, 1'b0);
        checkOutput("rstDropA", dropA, 1'b0);
        checkOutput("rstBusyB", busyB, 1'b0);
        transmitA = 1'b0; transmitB = 1'b0;
        rstA = 1'b0; rstB = 1'b0;
        tick();

        $display("[TB] single frame 8'hA5");
        applyStimulus(0, 8'hA5);
        checkOutput("startBitA5", txA, 1'b0);
        waitIdle(0, 200);

        $display("[TB] back-to-back 8'h00 then 8'hFF");
        applyStimulus(0, 8'h00);
        waitIdle(0, 200);
        applyStimulus(0, 8'hFF);
        checkOutput("b2bStartTx", txA, 1'b0);
        checkOutput("b2bBusy", busyA, 1'b1);
        waitIdle(0, 200);

        $display("[TB] busy drop during 8'h55");
        applyStimulus(0, 8'h55);
        repeat (9) tick();
        applyStimulus(0, 8'h33);
        checkOutput("dropPulse", dropA, 1'b1);
        tick();
        checkOutput("dropCleared", dropA, 1'b0);
        waitIdle(0, 200);

        $display("[TB] reset mid-frame of 8'hC3");
        applyStimulus(0, 8'hC3);
        repeat (15) tick();
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        checkOutput("midRstTx", txA, 1'b1);
        checkOutput("midRstBusy", busyA, 1'b0);
        tick();
        applyStimulus(0, 8'h3C);
        waitIdle(0, 200);

        $display("[TB] two stop bits 8'h81 and parity pattern 8'h07");
        applyStimulus(1, 8'h81);
        waitIdle(1, 200);
        applyStimulus(1, 8'h07);
        waitIdle(1, 200);
        applyStimulus(0, 8'h07);
        waitIdle(0, 200);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 800; cyc++) begin
            transmitA = ($urandom_range(0, 11) == 0);
            transmitB = ($urandom_range(0, 11) == 0);
            byteA = 8'($urandom);
            byteB = 8'($urandom);
            rstA = ($urandom_range(0, 299) == 0);
            rstB = ($urandom_range(0, 299) == 0);
            tick();
        end
        transmitA = 1'b0; transmitB = 1'b0;
        rstA = 1'b0; rstB = 1'b0;
        waitIdle(0, 200);
        waitIdle(1, 200);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
